wm_cycle_controller: RTL

//   Wash-cycle sequencer for the washing-machine controller.

---
 rtl/wm_cycle_controller.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/wm_cycle_controller.sv
// rtl/wm_cycle_controller.sv - wash-cycle sequencer: phase FSM, actuators, watchdog, door and cancel supervision
module wm_cycle_controller #(
    parameter int LOCK_CYCLES   = 4,
    parameter int PHASE_TIMEOUT = 64,
    parameter int WDOG_W        = 7
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       cancel,
    input  logic       cold_wash,
    input  logic       no_spin,
    input  logic       door_closed,
    input  logic       sig_Full,
    input  logic       sig_Temperature,
    input  logic       sig_Completed,
    output logic [2:0] state,
    output logic       door_lock,
    output logic       water_valve,
    output logic       heater,
    output logic       motor,
    output logic       motor_fast,
    output logic       done,
    output logic       aborted,
    output logic       fault,
    output logic [1:0] fault_code
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOCK  = 3'd1,
        S_FILL  = 3'd2,
        S_HEAT  = 3'd3,
        S_WASH  = 3'd4,
        S_RINSE = 3'd5,
        S_SPIN  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              arm_q, arm_d;
    logic              cold_q, cold_d;
    logic              nospin_q, nospin_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              fault_q, fault_d;
    logic [1:0]        fault_code_q, fault_code_d;
    logic [4:0]        act_q, act_d;

    logic   timed;
    logic   phase_in;
    state_t next_phase;

    always_comb begin
        timed = (state_q == S_FILL) || (state_q == S_HEAT) || (state_q == S_WASH)
             || (state_q == S_RINSE) || (state_q == S_SPIN);

        case (state_q)
            S_FILL:  phase_in = sig_Full;
            S_HEAT:  phase_in = sig_Temperature;
            S_WASH,
            S_RINSE,
            S_SPIN:  phase_in = sig_Completed;
            default: phase_in = 1'b0;
        endcase

        case (state_q)
            S_FILL:  next_phase = cold_q ? S_WASH : S_HEAT;
            S_HEAT:  next_phase = S_WASH;
            S_WASH:  next_phase = S_RINSE;
            S_RINSE: next_phase = nospin_q ? S_DONE : S_SPIN;
            S_SPIN:  next_phase = S_DONE;
            default: next_phase = S_IDLE;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        wdog_d       = wdog_q;
        arm_d        = arm_q;
        cold_d       = cold_q;
        nospin_d     = nospin_q;
        aborted_d    = aborted_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && door_closed) begin
                    state_d      = S_LOCK;
                    cold_d       = cold_wash;
                    nospin_d     = no_spin;
                    aborted_d    = 1'b0;
                    fault_d      = 1'b0;
                    fault_code_d = 2'b00;
                end
            end
            default: begin
                // Supervision outranks phase progress: door, then watchdog, then cancel.
                if (!door_closed) begin
                    state_d      = S_IDLE;
                    fault_d      = 1'b1;
                    fault_code_d = 2'b10;
                end else if (timed && (wdog_q == WDOG_W'(PHASE_TIMEOUT - 1))) begin
                    state_d      = S_IDLE;
                    fault_d      = 1'b1;
                    fault_code_d = 2'b01;
                end else if (cancel) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (state_q == S_LOCK) begin
                    if (lock_cnt_q == LC_W'(LOCK_CYCLES - 1)) begin
                        state_d = S_FILL;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LC_W'(1);
                    end
                end else if (arm_q && phase_in) begin
                    state_d = next_phase;
                end else begin
                    // A high seen before any low is stale from the previous phase.
                    arm_d  = arm_q | ~phase_in;
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
        endcase

        if (state_d != state_q) begin
            lock_cnt_d = '0;
            wdog_d     = '0;
            arm_d      = 1'b0;
        end

        case (state_d)
            S_LOCK:         act_d = 5'b10000;
            S_FILL:         act_d = 5'b11000;
            S_HEAT:         act_d = 5'b10100;
            S_WASH, S_RINSE: act_d = 5'b10010;
            S_SPIN:         act_d = 5'b10011;
            default:        act_d = 5'b00000;
        endcase

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            lock_cnt_q   <= '0;
            wdog_q       <= '0;
            arm_q        <= 1'b0;
            cold_q       <= 1'b0;
            nospin_q     <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            act_q        <= 5'b00000;
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            wdog_q       <= wdog_d;
            arm_q        <= arm_d;
            cold_q       <= cold_d;
            nospin_q     <= nospin_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            act_q        <= act_d;
        end
    end

    assign state       = state_q;
    assign door_lock   = act_q[4];
    assign water_valve = act_q[3];
    assign heater      = act_q[2];
    assign motor       = act_q[1];
    assign motor_fast  = act_q[0];
    assign done        = done_q;
    assign aborted     = aborted_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

endmodule
